tx_pipe_arbiter: RTL and testbench
==================================

Name: tx_pipe_arbiter

Overview:
- Shares the single AHIR read-pipe interface that feeds the MAC-side AXI-s transmitter between two packet queues (q0, q1).
- Polls the queues round-robin and locks onto a queue for a whole packet, releasing only after the word with the tlast bit has been delivered.
- Holds a one-word buffer between the queues and the transmitter, and keeps per-queue packet counters for status.

Parameters:
- N, 64, data width in bits.
- S, 8, keep-field width.
- D, N+S+1, pipe word width; bit D-1 = tlast, bits D-2:S = data, bits S-1:0 = keep.
- CW, 16, packet counter width.

Ports:
- clk  in  1  system clock; all state on rising edge
- resetn  in  1  asynchronous active-low reset
- q0_req  out  1  read request to queue 0 pipe
- q0_ack  in  1  queue 0 pipe ack; q0_data valid when high with q0_req
- q0_data  in  D  queue 0 pipe word
- q1_req  out  1  read request to queue 1 pipe
- q1_ack  in  1  queue 1 ack
- q1_data  in  D  queue 1 pipe word
- out_req  in  1  read request from transmitter
- out_ack  out  1  word delivered this cycle
- out_data  out  D  buffered word
- grant  out  2  one-hot locked queue ({q1,q0}); 00 when polling
- busy  out  1  high while locked to a queue or buffer full
- pkt_cnt0  out  CW  packets delivered from q0
- pkt_cnt1  out  CW  packets delivered from q1

Behaviour:
- Reset (async, resetn=0):
  - state=POLL, ptr=0, buf_full=0, buffer=0.
  - pkt_cnt0=pkt_cnt1=0, grant=00, busy=0.
  - q0_req=q1_req=0 while resetn=0.
  - Reset mid-packet drops the partial packet. No recovery of the remaining words.
- Request outputs:
  - qX_req is decoded from registers only: high when buf_full=0 and either (state=POLL and ptr=X) or (state=LOCK and grant selects X).
  - No combinational path from qX_ack to any qX_req.
- Capture:
  - A cycle with qX_req=1 and qX_ack=1 loads qX_data into the buffer and sets buf_full at the edge.
  - qX_req drops the following cycle.
  - ack with req low is ignored.
- States:
  - POLL:
    - ack from ptr queue → capture, state=LOCK, grant=onehot(ptr).
    - No ack → ptr toggles next cycle, so each queue is polled for exactly one cycle, alternating.
  - LOCK: request the granted queue only, whenever the buffer is empty. Other queue req=0.
- Output handshake:
  - out_ack = buf_full & out_req (combinational). out_data = buffer, stable while buf_full.
  - On out_ack, buf_full clears at the edge.
  - If the delivered word has bit D-1=1:
    - increment the pkt_cnt of the granted queue (wraps modulo 2^CW);
    - state=POLL, grant=00, ptr=other queue (fairness: the other queue is polled first).
- Throughput: at most one word per 2 cycles (capture edge, then deliver edge). No refill in the same cycle as delivery.
- Single-word packet (tlast on the first word): LOCK is entered and exited after one delivery. pkt_cnt increments once.
- busy = (state=LOCK) | buf_full.
- out_req held low: the buffer holds indefinitely and no further queue reads occur.
- Both queues idle: continuous alternating polling. grant=00, counters unchanged.

Test Plan:
- Reset, out_req=1, both queues never ack → q0_req and q1_req alternate each cycle starting with q0; out_ack=0; grant=00.
- q0 supplies 3 words (last has bit72=1), out_req=1 → out_data sequence matches the 3 words, out_ack on every other cycle, grant=01 throughout, q1_req=0 throughout, pkt_cnt0=1 after the third delivery, then the first polled queue is q1.
- Both queues continuously hold 2-word packets → packets delivered alternately q0,q1,q0,q1. After 4 packets pkt_cnt0=2, pkt_cnt1=2. Words from different queues never interleave.
- Buffer full with out_req=0 for 10 cycles → out_ack=0, q*_req=0, out_data constant. out_req=1 → out_ack=1 for exactly one cycle.
- Preload pkt_cnt0=16'hFFFF via 65535 single-word q0 packets (or force) → the next q0 packet gives pkt_cnt0=0.
- Assert resetn=0 mid-packet (after word 2 of 4) → all outputs are at reset values immediately, without waiting for a clock edge. After release, polling restarts at q0 and the remaining words are not delivered.

Source files
------------

// File: rtl/tx_pipe_arbiter.sv
// tx_pipe_arbiter: round-robin, packet-locked sharing of one AHIR read pipe between two queues,
// with a one-word buffer toward the AXI-s transmitter and per-queue packet counters.
module tx_pipe_arbiter #(
    parameter int N  = 64,
    parameter int S  = 8,
    parameter int D  = N + S + 1,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          resetn,
    output logic          q0_req,
    input  logic          q0_ack,
    input  logic [D-1:0]  q0_data,
    output logic          q1_req,
    input  logic          q1_ack,
    input  logic [D-1:0]  q1_data,
    input  logic          out_req,
    output logic          out_ack,
    output logic [D-1:0]  out_data,
    output logic [1:0]    grant,
    output logic          busy,
    output logic [CW-1:0] pkt_cnt0,
    output logic [CW-1:0] pkt_cnt1
);
    localparam logic POLL = 1'b0;
    localparam logic LOCK = 1'b1;

    logic          state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          full_q, full_d;
    logic [1:0]    grant_q, grant_d;
    logic [D-1:0]  buf_q, buf_d;
    logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic          cap0, cap1, last_del;

    // Requests come only from registers (and the reset pin), never from the acks.
    assign q0_req   = resetn & ~full_q & (state_q == LOCK ? grant_q[0] : ~ptr_q);
    assign q1_req   = resetn & ~full_q & (state_q == LOCK ? grant_q[1] : ptr_q);
    assign cap0     = q0_req & q0_ack;
    assign cap1     = q1_req & q1_ack;
    assign out_ack  = full_q & out_req;
    assign out_data = buf_q;
    assign grant    = grant_q;
    assign busy     = (state_q == LOCK) | full_q;
    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
    assign last_del = out_ack & buf_q[D-1];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        buf_d   = buf_q;
        full_d  = full_q;
        if (cap0 | cap1) begin
            buf_d  = cap1 ? q1_data : q0_data;
            full_d = 1'b1;
        end else if (out_ack) begin
            full_d = 1'b0;
        end
        if (state_q == POLL) begin
            if (cap0 | cap1) begin
                state_d = LOCK;
                grant_d = {cap1, cap0};
            end else begin
                ptr_d = ~ptr_q;
            end
        end else if (last_del) begin
            // Hand the first poll slot to the queue that just lost the lock.
            state_d = POLL;
            grant_d = 2'b00;
            ptr_d   = grant_q[0];
            cnt0_d  = cnt0_q + CW'(grant_q[0]);
            cnt1_d  = cnt1_q + CW'(grant_q[1]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= POLL;
            ptr_q   <= 1'b0;
            full_q  <= 1'b0;
            grant_q <= 2'b00;
            buf_q   <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            full_q  <= full_d;
            grant_q <= grant_d;
            buf_q   <= buf_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end
endmodule

// File: tb/tb_tx_pipe_arbiter.sv
// tb_tx_pipe_arbiter: directed bench for tx_pipe_arbiter with hand-computed expectations
module tb_tx_pipe_arbiter;
  localparam int N  = 64;
  localparam int S  = 8;
  localparam int D  = N + S + 1;
  localparam int CW = 16;
  logic          clk = 1'b0, resetn = 1'b0;
  logic          q0_ack = 1'b0, q1_ack = 1'b0, out_req = 1'b0;
  logic [D-1:0]  q0_data = '0, q1_data = '0;
  logic          q0_req, q1_req, out_ack, busy;
  logic [D-1:0]  out_data;
  logic [1:0]    grant;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;
  int n_chk = 0, n_fail = 0;
  int ndel, i0, i1, p, ei;
  logic c0, c1, eq, ev;
  logic [D-1:0] ew, x, zero;
  always #5 clk = ~clk;
  tx_pipe_arbiter #(.N(N), .S(S), .D(D), .CW(CW)) dut (
    .clk(clk), .resetn(resetn),
    .q0_req(q0_req), .q0_ack(q0_ack), .q0_data(q0_data),
    .q1_req(q1_req), .q1_ack(q1_ack), .q1_data(q1_data),
    .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
    .grant(grant), .busy(busy), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );
  function automatic logic [D-1:0] mk(input logic l, input logic [63:0] d);
    return {l, d, 8'hFF};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ck(input string t, input logic ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", t);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
  initial begin
    zero = '0;
    out_req = 1'b1;
    #2;
    ck("rst_q0_req", q0_req === 1'b0);
    ck("rst_q1_req", q1_req === 1'b0);
    ck("rst_out_ack", out_ack === 1'b0);
    ck("rst_grant", grant === 2'b00);
    ck("rst_busy", busy === 1'b0);
    ck("rst_cnt0", pkt_cnt0 === 16'd0);
    ck("rst_cnt1", pkt_cnt1 === 16'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      ev = (i % 2 == 0);
      ck("idle_q0_req", q0_req === ev);
      ck("idle_q1_req", q1_req === ~ev);
      ck("idle_out_ack", out_ack === 1'b0);
      ck("idle_grant", grant === 2'b00);
      tick();
    end
    q0_ack = 1'b1;
    q0_data = mk(1'b0, 64'h1111_0000_0000_0001);
    ck("p3_q0_req0", q0_req === 1'b1);
    tick();
    ck("p3_ack0", out_ack === 1'b1);
    ck("p3_data0", out_data === mk(1'b0, 64'h1111_0000_0000_0001));
    ck("p3_grant0", grant === 2'b01);
    ck("p3_q1_req0", q1_req === 1'b0);
    ck("p3_q0_req_full", q0_req === 1'b0);
    ck("p3_busy", busy === 1'b1);
    tick();
    q0_data = mk(1'b0, 64'h2222_0000_0000_0002);
    ck("p3_q0_req1", q0_req === 1'b1);
    ck("p3_gap_ack", out_ack === 1'b0);
    ck("p3_q1_req1", q1_req === 1'b0);
    ck("p3_grant1", grant === 2'b01);
    tick();
    ck("p3_ack1", out_ack === 1'b1);
    ck("p3_data1", out_data === mk(1'b0, 64'h2222_0000_0000_0002));
    tick();
    q0_data = mk(1'b1, 64'h3333_0000_0000_0003);
    tick();
    ck("p3_ack2", out_ack === 1'b1);
    ck("p3_data2", out_data === mk(1'b1, 64'h3333_0000_0000_0003));
    ck("p3_cnt0_pre", pkt_cnt0 === 16'd0);
    tick();
    q0_ack = 1'b0;
    ck("p3_cnt0", pkt_cnt0 === 16'd1);
    ck("p3_grant_end", grant === 2'b00);
    ck("p3_next_q1", q1_req === 1'b1);
    ck("p3_next_q0", q0_req === 1'b0);
    ck("p3_busy_end", busy === 1'b0);
    q0_ack = 1'b1; q1_ack = 1'b1;
    i0 = 0; i1 = 0; ndel = 0;
    q0_data = mk(1'b0, {8'hA0, 56'(0)});
    q1_data = mk(1'b0, {8'hB1, 56'(0)});
    for (int cyc = 0; cyc < 60 && ndel < 8; cyc++) begin
      c0 = q0_req & q0_ack;
      c1 = q1_req & q1_ack;
      if (out_ack) begin
        p  = ndel / 2;
        eq = (p % 2 == 0);
        ei = (p / 2) * 2 + ndel % 2;
        ew = mk(ndel % 2 == 1, {eq ? 8'hB1 : 8'hA0, 56'(ei)});
        ck("rr_data", out_data === ew);
        ck("rr_grant", grant === (eq ? 2'b10 : 2'b01));
        ndel++;
      end
      tick();
      if (c0) begin i0++; q0_data = mk(i0 % 2 == 1, {8'hA0, 56'(i0)}); end
      if (c1) begin i1++; q1_data = mk(i1 % 2 == 1, {8'hB1, 56'(i1)}); end
    end
    q0_ack = 1'b0; q1_ack = 1'b0;
    ck("rr_deliveries", ndel === 8);
    ck("rr_cnt0", pkt_cnt0 === 16'd3);
    ck("rr_cnt1", pkt_cnt1 === 16'd2);
    out_req = 1'b0;
    x = mk(1'b1, 64'hDEAD_BEEF_0000_0004);
    q1_ack = 1'b1; q1_data = x;
    ck("st_q1_req", q1_req === 1'b1);
    tick();
    q1_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ck("st_out_ack", out_ack === 1'b0);
      ck("st_q0_req", q0_req === 1'b0);
      ck("st_q1_req_hold", q1_req === 1'b0);
      ck("st_data", out_data === x);
      tick();
    end
    out_req = 1'b1;
    #1;
    ck("st_release_ack", out_ack === 1'b1);
    tick();
    ck("st_ack_once", out_ack === 1'b0);
    ck("st_cnt1", pkt_cnt1 === 16'd3);
    ck("st_grant", grant === 2'b00);
    force dut.cnt0_q = 16'hFFFF;
    #1 release dut.cnt0_q;
    #1;
    ck("wr_preload", pkt_cnt0 === 16'hFFFF);
    ck("wr_q0_req", q0_req === 1'b1);
    q0_ack = 1'b1; q0_data = mk(1'b1, 64'h5555_0000_0000_0005);
    tick();
    q0_ack = 1'b0;
    ck("wr_ack", out_ack === 1'b1);
    ck("wr_data", out_data === mk(1'b1, 64'h5555_0000_0000_0005));
    tick();
    ck("wr_cnt0", pkt_cnt0 === 16'd0);
    ck("wr_cnt1", pkt_cnt1 === 16'd3);
    ck("mr_q1_req", q1_req === 1'b1);
    q1_ack = 1'b1; q1_data = mk(1'b0, 64'h7000_0000_0000_0000);
    tick();
    ck("mr_data0", out_data === mk(1'b0, 64'h7000_0000_0000_0000));
    tick();
    q1_data = mk(1'b0, 64'h7000_0000_0000_0001);
    tick();
    ck("mr_data1", out_data === mk(1'b0, 64'h7000_0000_0000_0001));
    tick();
    q1_data = mk(1'b0, 64'h7000_0000_0000_0002);
    tick();
    ck("mr_busy", busy === 1'b1);
    resetn = 1'b0;
    #1;
    ck("mr_q0_req", q0_req === 1'b0);
    ck("mr_q1_req_rst", q1_req === 1'b0);
    ck("mr_out_ack", out_ack === 1'b0);
    ck("mr_grant", grant === 2'b00);
    ck("mr_busy_rst", busy === 1'b0);
    ck("mr_cnt0", pkt_cnt0 === 16'd0);
    ck("mr_cnt1", pkt_cnt1 === 16'd0);
    ck("mr_data_rst", out_data === zero);
    q1_ack = 1'b0; q1_data = mk(1'b1, 64'h7000_0000_0000_0003);
    #1 resetn = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      ev = (i % 2 == 0);
      ck("mr_poll_q0", q0_req === ev);
      ck("mr_poll_q1", q1_req === ~ev);
      ck("mr_no_deliver", out_ack === 1'b0);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
